// File: rtl/grayblast_pkg.sv
// Shared types and constants for the gray pixel responder and its byte FIFO.
package grayblast_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int PIXEL_W         = 4;
    localparam int BYTE_W          = 8;
    localparam int PIXELS_PER_BYTE = 2;

    // Substitute pixel shown when the FIFO runs dry: low two count nibbles folded together.
    function automatic logic [PIXEL_W-1:0] pattern_pixel(input logic [7:0] count_lo);
        return count_lo[3:0] ^ count_lo[7:4];
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with flush; head byte is presented combinationally.
module sync_byte_fifo
    import grayblast_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] push_data,
    output logic [BYTE_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_data = mem[rd_ptr[AW-1:0]];
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;

    // Pointer update; flush wins over push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= (AW+1)'(0);
            rd_ptr <= (AW+1)'(0);
        end else if (flush) begin
            wr_ptr <= (AW+1)'(0);
            rd_ptr <= (AW+1)'(0);
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/frame_pixel_responder.sv
// Framebuffer-side responder: serves 4-bit gray pixels on VGA strobes from a buffered byte stream.
// Define PATTERN_FALLBACK_EN to emit a count-derived pattern instead of 0 on underflow.
module frame_pixel_responder
    import grayblast_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int FRAME_PIXELS = 19200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_reset_in,
    input  logic               frame_next_pixel_in,
    output logic [PIXEL_W-1:0] frame_pixel_out,
    input  logic [BYTE_W-1:0]  wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic               sof_req_out,
    output logic               underflow_out,
    output logic               frame_done_out
);

    localparam int             CW   = $clog2(FRAME_PIXELS + 1);
    localparam logic [CW-1:0]  LAST = CW'(FRAME_PIXELS - 1);

    state_t             state;
    logic               nib_sel;
    logic [CW-1:0]      count;
    logic               fifo_flush;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [BYTE_W-1:0]  head;
    logic [PIXEL_W-1:0] head_pixel;
    logic [PIXEL_W-1:0] fallback_pixel;

    // Ready looks only at registered state, so a popping full FIFO still refuses this cycle.
    assign wr_ready   = (state == STREAM) && !full;
    assign fifo_flush = frame_reset_in || (state == FLUSH);
    assign push       = wr_valid && wr_ready && !frame_reset_in;
    assign pop        = (state == STREAM) && frame_next_pixel_in && !frame_reset_in
                        && !empty && nib_sel;
    assign head_pixel = nib_sel ? head[7:4] : head[3:0];

`ifdef PATTERN_FALLBACK_EN
    logic [7:0] count_lo;
    assign count_lo       = 8'(count);
    assign fallback_pixel = pattern_pixel(count_lo);
`else
    assign fallback_pixel = 4'd0;
`endif

    sync_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (fifo_flush),
        .push     (push),
        .pop      (pop),
        .push_data(wr_data),
        .head_data(head),
        .full     (full),
        .empty    (empty)
    );

    // Frame FSM with nibble select, pixel counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            nib_sel         <= 1'b0;
            count           <= CW'(0);
            frame_pixel_out <= 4'd0;
            sof_req_out     <= 1'b0;
            underflow_out   <= 1'b0;
            frame_done_out  <= 1'b0;
        end else if (frame_reset_in) begin
            state           <= FLUSH;
            nib_sel         <= 1'b0;
            count           <= CW'(0);
            frame_pixel_out <= 4'd0;
            sof_req_out     <= 1'b1;
            underflow_out   <= 1'b0;
            frame_done_out  <= 1'b0;
        end else begin
            sof_req_out <= 1'b0;
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                FLUSH: begin
                    state           <= STREAM;
                    nib_sel         <= 1'b0;
                    count           <= CW'(0);
                    frame_pixel_out <= 4'd0;
                    underflow_out   <= 1'b0;
                    frame_done_out  <= 1'b0;
                end
                STREAM: begin
                    if (frame_next_pixel_in) begin
                        count <= count + CW'(1);
                        if (!empty) begin
                            frame_pixel_out <= head_pixel;
                            nib_sel         <= ~nib_sel;
                        end else begin
                            frame_pixel_out <= fallback_pixel;
                            underflow_out   <= 1'b1;
                        end
                        if (count == LAST) begin
                            state          <= DONE;
                            frame_done_out <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end else begin
                        state <= STREAM;
                    end
                end
                DONE: begin
                    frame_pixel_out <= 4'd0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pixel_responder.sv
// Randomized bench for frame_pixel_responder against a queue-based behavioural model.
module tb_frame_pixel_responder;

    localparam int FP    = 100;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_reset_in;
    logic       frame_next_pixel_in;
    logic [3:0] frame_pixel_out;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       sof_req_out;
    logic       underflow_out;
    logic       frame_done_out;

    always #5 clk = ~clk;

    frame_pixel_responder #(
        .FIFO_DEPTH  (DEPTH),
        .FRAME_PIXELS(FP)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .frame_reset_in     (frame_reset_in),
        .frame_next_pixel_in(frame_next_pixel_in),
        .frame_pixel_out    (frame_pixel_out),
        .wr_data            (wr_data),
        .wr_valid           (wr_valid),
        .wr_ready           (wr_ready),
        .sof_req_out        (sof_req_out),
        .underflow_out      (underflow_out),
        .frame_done_out     (frame_done_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: pending pixels as a nibble queue; phase 0 idle, 1 flush, 2 stream, 3 done.
    int q[$];
    int m_cnt  = 0;
    int m_pix  = 0;
    int m_udf  = 0;
    int m_done = 0;
    int m_sof  = 0;
    int phase  = 0;

    function automatic int fallback(input int c);
`ifdef PATTERN_FALLBACK_EN
        return (c & 15) ^ ((c >> 4) & 15);
`else
        return 0;
`endif
    endfunction

    function automatic int m_ready();
        return ((phase == 2) && (((q.size() + 1) / 2) < DEPTH)) ? 1 : 0;
    endfunction

    task automatic check_value(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit n, input bit v, input logic [7:0] d);
        int rdy;
        rst_n               = r;
        frame_reset_in      = f;
        frame_next_pixel_in = n;
        wr_valid            = v;
        wr_data             = d;
        rdy = m_ready();
        if (!r) begin
            q.delete();
            m_cnt = 0; m_pix = 0; m_udf = 0; m_done = 0; m_sof = 0; phase = 0;
        end else if (f) begin
            q.delete();
            m_cnt = 0; m_pix = 0; m_udf = 0; m_done = 0; m_sof = 1; phase = 1;
        end else begin
            m_sof = 0;
            case (phase)
                1: phase = 2;
                2: begin
                    if (n) begin
                        if (q.size() > 0) m_pix = q.pop_front();
                        else begin
                            m_pix = fallback(m_cnt);
                            m_udf = 1;
                        end
                        m_cnt++;
                        if (m_cnt == FP) begin
                            phase  = 3;
                            m_done = 1;
                        end
                    end
                    if (v && rdy == 1) begin
                        q.push_back(int'(d[3:0]));
                        q.push_back(int'(d[7:4]));
                    end
                end
                3: m_pix = 0;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        check_value("pixel", int'(frame_pixel_out), m_pix);
        check_value("wr_ready", int'(wr_ready), m_ready());
        check_value("sof_req", int'(sof_req_out), m_sof);
        check_value("underflow", int'(underflow_out), m_udf);
        check_value("frame_done", int'(frame_done_out), m_done);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic strobe();
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic restart();
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check_value("dir_sof_pulse", int'(sof_req_out), 1);
        idle();
        check_value("dir_sof_end", int'(sof_req_out), 0);
        check_value("dir_ready_after_flush", int'(wr_ready), 1);
    endtask

    initial begin
        int acc;
        frame_reset_in = 1'b0; frame_next_pixel_in = 1'b0;
        wr_valid = 1'b0; wr_data = 8'h00; rst_n = 1'b0;

        // Reset state, and IDLE ignores strobes and writes
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
        check_value("dir_reset_ready", int'(wr_ready), 0);
        check_value("dir_reset_pixel", int'(frame_pixel_out), 0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
        check_value("dir_idle_ready", int'(wr_ready), 0);

        // Frame start and in-order nibble delivery
        restart();
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h21);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h43);
        for (int i = 1; i <= 4; i++) begin
            strobe();
            check_value("dir_pixel_seq", int'(frame_pixel_out), i);
        end
        check_value("dir_no_underflow", int'(underflow_out), 0);

        // Fill: exactly DEPTH bytes accepted, then one popped byte reopens ready
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (wr_ready) acc++;
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'($urandom));
        end
        check_value("dir_fill_count", acc, DEPTH);
        check_value("dir_full_ready", int'(wr_ready), 0);
        strobe();
        check_value("dir_half_pop_ready", int'(wr_ready), 0);
        strobe();
        check_value("dir_pop_ready", int'(wr_ready), 1);

        // Underflow at count 0x35, sticky until the next frame reset
        restart();
        for (int i = 0; i < 'h35; i++) strobe();
        strobe();
`ifdef PATTERN_FALLBACK_EN
        check_value("dir_underflow_pixel", int'(frame_pixel_out), 6);
`else
        check_value("dir_underflow_pixel", int'(frame_pixel_out), 0);
`endif
        check_value("dir_underflow_flag", int'(underflow_out), 1);
        idle(); idle();
        check_value("dir_underflow_sticky", int'(underflow_out), 1);
        restart();
        check_value("dir_underflow_clear", int'(underflow_out), 0);

        // Frame completion
        for (int i = 0; i < FP; i++) strobe();
        check_value("dir_done_flag", int'(frame_done_out), 1);
        check_value("dir_done_ready", int'(wr_ready), 0);
        strobe();
        check_value("dir_done_pixel", int'(frame_pixel_out), 0);

        // Frame reset colliding with a strobe and a write mid-frame
        restart();
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h21);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h43);
        strobe();
        check_value("dir_mid_pixel", int'(frame_pixel_out), 1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h9a);
        check_value("dir_collide_sof", int'(sof_req_out), 1);
        check_value("dir_collide_pixel", int'(frame_pixel_out), 0);
        idle();
        strobe();
        check_value("dir_collide_empty", int'(underflow_out), 1);

        // Randomized traffic, all outputs compared every cycle
        restart();
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(799) != 0),
                 ($urandom_range(249) == 0),
                 ($urandom_range(99) < 45),
                 ($urandom_range(99) < 60),
                 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
